// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: LSB-first add through one full-adder cell, WIDTH cycles per result.
// Optional subtract mode is built in when the macro SERIAL_SUB_EN is defined (adds the sub port).

module add_one_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_sh_reg, a_sh_next;
    logic [WIDTH-1:0] b_sh_reg, b_sh_next;
    logic [WIDTH-1:0] sum_sh_reg, sum_sh_next;
    logic             carry_reg, carry_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic             fa_sum, fa_cout;

    add_one_bit u_fa (
        .a    (a_sh_reg[0]),
        .b    (b_sh_reg[0]),
        .cin  (carry_reg),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            a_sh_reg   <= '0;
            b_sh_reg   <= '0;
            sum_sh_reg <= '0;
            carry_reg  <= 1'b0;
            cnt_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            a_sh_reg   <= a_sh_next;
            b_sh_reg   <= b_sh_next;
            sum_sh_reg <= sum_sh_next;
            carry_reg  <= carry_next;
            cnt_reg    <= cnt_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        a_sh_next   = a_sh_reg;
        b_sh_next   = b_sh_reg;
        sum_sh_next = sum_sh_reg;
        carry_next  = carry_reg;
        cnt_next    = cnt_reg;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;

        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_sh_next = a;
                    cnt_next  = '0;
`ifdef SERIAL_SUB_EN
                    // Two's-complement subtract: a + ~b + 1
                    b_sh_next  = sub ? ~b : b;
                    carry_next = sub;
`else
                    b_sh_next  = b;
                    carry_next = 1'b0;
`endif
                    state_next = RUN;
                end
            end
            RUN: begin
                busy        = 1'b1;
                a_sh_next   = a_sh_reg >> 1;
                b_sh_next   = b_sh_reg >> 1;
                sum_sh_next = {fa_sum, sum_sh_reg[WIDTH-1:1]};
                carry_next  = fa_cout;
                cnt_next    = cnt_reg + CW'(1);
                if (cnt_reg == CW'(WIDTH - 1))
                    state_next = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign sum  = sum_sh_reg;
    assign cout = carry_reg;

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 clk  input  1  rising-edge clock; single clock domain.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  operand pair offered.
REQ-005 in_ready  output  1  block can accept operands.
REQ-006 a  input  WIDTH  operand A.
REQ-007 b  input  WIDTH  operand B.
REQ-008 sub  input  1  subtract request, sampled with operands; present only when SERIAL_SUB_EN is defined.
REQ-009 out_valid  output  1  result available.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 sum  output  WIDTH  result bits.
REQ-012 cout  output  1  final carry out of the MSB.
REQ-013 busy  output  1  high in RUN and DONE.

Function
REQ-014 The block SHALL compute the result bit-serially, LSB first, with exactly one instance of the team's existing one-bit full adder (add_one_bit); no WIDTH-wide adder is permitted.
REQ-015 The state machine SHALL have three states: IDLE, RUN and DONE.
REQ-016 IDLE: in_ready=1, out_valid=0; on in_valid&&in_ready it SHALL load a and b into shift registers, clear the carry flop, clear the bit counter, and go to RUN.
REQ-017 RUN: each cycle the adder SHALL be fed a_sh[0], b_sh[0] and the carry flop; result shifts into sum_sh MSB; a_sh and b_sh shift right; carry flop <= adder cout; counter increments.
REQ-018 The block SHALL leave RUN after exactly WIDTH cycles (counter==WIDTH-1) and enter DONE.
REQ-019 Latency: with the accept edge at edge k, out_valid SHALL first be high after edge k+WIDTH.
REQ-020 DONE: out_valid=1; sum = full result; cout = carry flop; both SHALL hold stable until the out_valid&&out_ready edge, then the FSM goes to IDLE.
REQ-021 in_ready SHALL be 0 in RUN and DONE; in_valid there SHALL be ignored; a, b and sub changes there SHALL NOT affect the in-flight result.
REQ-022 Back-to-back: after the output handshake, at least one IDLE cycle SHALL occur before the next accept; a result is never overwritten before it is consumed.
REQ-023 Arithmetic: sum = (a+b) mod 2^WIDTH; cout = bit WIDTH of a+b; wrap-around SHALL be silent (no error flag).
REQ-024 out_ready in IDLE or RUN SHALL have no effect.

Reset
REQ-025 rst_n low SHALL asynchronously force IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0, carry flop=0, counter=0.
REQ-026 Reset asserted mid-RUN or mid-DONE SHALL discard the operation; no out_valid pulse follows reset release.
REQ-027 Reset deassertion takes effect on the first clk edge with rst_n high.

Configuration
REQ-028 Macro SERIAL_SUB_EN: when defined, the sub port exists; with sub=1 at accept, b SHALL be loaded inverted and the carry flop initialised to 1, so sum=(a-b) mod 2^WIDTH and cout=1 means no borrow.
REQ-029 Without SERIAL_SUB_EN, the sub port and its logic SHALL be absent, and the block SHALL add only.

Verification (WIDTH=8)
REQ-030 a=0x0F, b=0x01, out_ready=1 -> out_valid 8 cycles after accept, sum=0x10, cout=0, then IDLE.
REQ-031 a=0xFF, b=0x01 -> sum=0x00, cout=1 (wrap-around).
REQ-032 a=0x3C, b=0x42, out_ready held 0 for 5 cycles -> out_valid stays 1, sum=0x7E stable; handshake on cycle 6 -> IDLE next cycle.
REQ-033 Second in_valid with a=0x11 pulsed during RUN -> ignored; in_ready=0; first result unaffected.
REQ-034 rst_n low at RUN cycle 4 -> immediate IDLE, sum=0, no out_valid; then a=0x01, b=0x01 -> sum=0x02.
REQ-035 SERIAL_SUB_EN defined: a=0x05, b=0x07, sub=1 -> sum=0xFE, cout=0; a=0x07, b=0x05, sub=1 -> sum=0x02, cout=1.
